// File: rtl/spi_ip_shift_register.sv
// SPI data-path shift register: parallel load of a word or half word, one bit
// launched per launch strobe and one bit captured per capture strobe, MSB- or
// LSB-first. The received bits collect in the register and a level flag marks
// completion. Strobes come from the SPI clock-generation/control block.
module spi_ip_shift_register #(
  parameter int PARAM_SR_WIDTH = 16
) (
  input  logic                      sr_clk_i,
  input  logic                      sr_rst_i,
  input  logic [PARAM_SR_WIDTH-1:0] sr_data_load_i,
  input  logic [1:0]                sr_load_type_i,
  input  logic                      sr_load_i,
  input  logic                      sr_enable_launch_i,
  input  logic                      sr_enable_capture_i,
  input  logic                      sr_enable_launch_capture_i,
  input  logic                      sr_data_serial_i,
  output logic [PARAM_SR_WIDTH-1:0] sr_data_out_o,
  output logic                      sr_data_serial_o,
  output logic                      sr_data_ready_o
);

  localparam int W  = PARAM_SR_WIDTH;
  localparam int H  = W / 2;
  localparam int CW = $clog2(W) + 1;

  localparam logic [CW-1:0] LEN_WORD   = CW'(W);
  localparam logic [CW-1:0] LEN_HALF   = CW'(H);
  localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [1:0]    TYPE_RESET = 2'b01;  // word, MSB-first

  // Load type encoding: bit0 = word (1) / half word (0), bit1 = LSB-first (1)
  localparam logic [1:0] TYPE_HW_MSB = 2'b00;
  localparam logic [1:0] TYPE_W_MSB  = 2'b01;
  localparam logic [1:0] TYPE_HW_LSB = 2'b10;
  localparam logic [1:0] TYPE_W_LSB  = 2'b11;

  logic [W-1:0]  sr_q,     sr_d;
  logic          serial_q, serial_d;
  logic          ready_q,  ready_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [1:0]    type_q,   type_d;

  logic [CW-1:0] len_s;
  logic          active_s;
  logic          launch_en_s;
  logic          capture_en_s;
  logic          launch_bit_s;
  logic [W-1:0]  shifted_s;
  logic [W-1:0]  load_val_s;

  // Next register value after one capture; half-word modes keep the upper half cleared
  function automatic logic [W-1:0] shift_field(input logic [W-1:0] cur,
                                               input logic [1:0]   ltype,
                                               input logic         si);
    logic [W-1:0] res;
    res = {W{1'b0}};
    case (ltype)
      TYPE_HW_MSB: res = {{H{1'b0}}, cur[H-2:0], si};
      TYPE_W_MSB:  res = {cur[W-2:0], si};
      TYPE_HW_LSB: res = {{H{1'b0}}, si, cur[H-1:1]};
      TYPE_W_LSB:  res = {si, cur[W-1:1]};
      default:     res = {W{1'b0}};
    endcase
    return res;
  endfunction

  // Bit that goes on the wire next: top of the active field or bit 0
  function automatic logic launch_bit(input logic [W-1:0] cur,
                                      input logic [1:0]   ltype);
    logic b;
    b = 1'b0;
    case (ltype)
      TYPE_HW_MSB: b = cur[H-1];
      TYPE_W_MSB:  b = cur[W-1];
      TYPE_HW_LSB: b = cur[0];
      TYPE_W_LSB:  b = cur[0];
      default:     b = 1'b0;
    endcase
    return b;
  endfunction

  // Derived transfer length, strobe qualification and datapath candidates
  always_comb begin
    len_s        = type_q[0] ? LEN_WORD : LEN_HALF;
    active_s     = (cnt_q < len_s);
    launch_en_s  = sr_enable_launch_i  & sr_enable_launch_capture_i & active_s;
    capture_en_s = sr_enable_capture_i & sr_enable_launch_capture_i & active_s;
    launch_bit_s = launch_bit(sr_q, type_q);
    shifted_s    = shift_field(sr_q, type_q, sr_data_serial_i);
    if (sr_load_type_i[0]) begin
      load_val_s = sr_data_load_i;
    end else begin
      load_val_s = {{H{1'b0}}, sr_data_load_i[H-1:0]};
    end
  end

  // Next-state selection: load wins over launch/capture; finished transfers hold
  always_comb begin
    sr_d     = sr_q;
    serial_d = serial_q;
    ready_d  = ready_q;
    cnt_d    = cnt_q;
    type_d   = type_q;
    if (sr_load_i) begin
      type_d  = sr_load_type_i;
      sr_d    = load_val_s;
      cnt_d   = CNT_ZERO;
      ready_d = 1'b0;
    end else begin
      // launch reads sr_q, so a same-cycle capture cannot disturb the launched bit
      if (launch_en_s) begin
        serial_d = launch_bit_s;
      end else begin
        serial_d = serial_q;
      end
      if (capture_en_s) begin
        sr_d  = shifted_s;
        cnt_d = cnt_q + CNT_ONE;
        if ((cnt_q + CNT_ONE) == len_s) begin
          ready_d = 1'b1;
        end else begin
          ready_d = ready_q;
        end
      end else begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
      end
    end
  end

  // State registers with synchronous reset overriding any load or transfer
  always_ff @(posedge sr_clk_i) begin
    if (sr_rst_i) begin
      sr_q     <= {W{1'b0}};
      serial_q <= 1'b0;
      ready_q  <= 1'b0;
      cnt_q    <= CNT_ZERO;
      type_q   <= TYPE_RESET;
    end else begin
      sr_q     <= sr_d;
      serial_q <= serial_d;
      ready_q  <= ready_d;
      cnt_q    <= cnt_d;
      type_q   <= type_d;
    end
  end

  assign sr_data_out_o    = sr_q;
  assign sr_data_serial_o = serial_q;
  assign sr_data_ready_o  = ready_q;

endmodule

// File: tb/tb_spi_ip_shift_register.sv
// Two shift registers cross-connected serial-out to serial-in; directed
// vectors exchange words and half words in both bit orders.
module tb_spi_ip_shift_register;

  logic        clk;
  logic        rst;
  logic [15:0] load_a, load_b;
  logic [1:0]  ltype;
  logic        load, launch, capture, gen;
  logic [15:0] out_a, out_b;
  logic        ser_a, ser_b;
  logic        rdy_a, rdy_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] da, db;     // parallel load data
    logic [1:0]  lt;         // load type
    int          pairs;      // launch/capture pairs per transfer
    logic [15:0] la, lb;     // register right after load
    logic [15:0] ea, eb;     // register after the transfer
    logic        fa, fb;     // first bit launched
  } vec_t;

  vec_t vecs [4];

  spi_ip_shift_register #(.PARAM_SR_WIDTH(16)) u_a (
    .sr_clk_i                   (clk),
    .sr_rst_i                   (rst),
    .sr_data_load_i             (load_a),
    .sr_load_type_i             (ltype),
    .sr_load_i                  (load),
    .sr_enable_launch_i         (launch),
    .sr_enable_capture_i        (capture),
    .sr_enable_launch_capture_i (gen),
    .sr_data_serial_i           (ser_b),
    .sr_data_out_o              (out_a),
    .sr_data_serial_o           (ser_a),
    .sr_data_ready_o            (rdy_a)
  );

  spi_ip_shift_register #(.PARAM_SR_WIDTH(16)) u_b (
    .sr_clk_i                   (clk),
    .sr_rst_i                   (rst),
    .sr_data_load_i             (load_b),
    .sr_load_type_i             (ltype),
    .sr_load_i                  (load),
    .sr_enable_launch_i         (launch),
    .sr_enable_capture_i        (capture),
    .sr_enable_launch_capture_i (gen),
    .sr_data_serial_i           (ser_a),
    .sr_data_out_o              (out_b),
    .sr_data_serial_o           (ser_b),
    .sr_data_ready_o            (rdy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] a, input logic [15:0] b, input logic [1:0] t);
    load_a = a; load_b = b; ltype = t; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic do_launch();
    launch = 1'b1;
    tick();
    launch = 1'b0;
  endtask

  task automatic do_capture();
    capture = 1'b1;
    tick();
    capture = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load_a = 16'h0000; load_b = 16'h0000; ltype = 2'b01;
    load = 1'b0; launch = 1'b0; capture = 1'b0; gen = 1'b1;

    vecs[0] = '{16'h1234, 16'h5678, 2'b01, 16, 16'h1234, 16'h5678, 16'h5678, 16'h1234, 1'b0, 1'b0};
    vecs[1] = '{16'h1E6A, 16'hA6E1, 2'b11, 16, 16'h1E6A, 16'hA6E1, 16'hA6E1, 16'h1E6A, 1'b0, 1'b1};
    vecs[2] = '{16'hFF12, 16'hBB34, 2'b00,  8, 16'h0012, 16'h0034, 16'h0034, 16'h0012, 1'b0, 1'b0};
    vecs[3] = '{16'hFF1E, 16'hBB6A, 2'b10,  8, 16'h001E, 16'h006A, 16'h006A, 16'h001E, 1'b0, 1'b0};

    tick();
    tick();
    rst = 1'b0;
    check("reset_data", out_a, 16'h0000);
    check("reset_ready", {15'd0, rdy_a}, 16'h0000);
    check("reset_serial", {15'd0, ser_a}, 16'h0000);

    // Global enable low: strobes must have no effect
    do_load(16'h8001, 16'h7FFE, 2'b01);
    gen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_launch();
      do_capture();
    end
    check("gen0_data_a", out_a, 16'h8001);
    check("gen0_data_b", out_b, 16'h7FFE);
    check("gen0_serial", {15'd0, ser_a}, 16'h0000);
    check("gen0_ready", {15'd0, rdy_a}, 16'h0000);
    gen = 1'b1;
    do_launch();
    check("gen1_launch", {15'd0, ser_a}, 16'h0001);
    // Load leaves the serial output alone
    do_load(16'h0000, 16'h0000, 2'b01);
    check("load_keeps_serial", {15'd0, ser_a}, 16'h0001);

    // Table-driven loopback transfers
    for (int v = 0; v < 4; v++) begin
      do_load(vecs[v].da, vecs[v].db, vecs[v].lt);
      check($sformatf("v%0d_load_a", v), out_a, vecs[v].la);
      check($sformatf("v%0d_load_b", v), out_b, vecs[v].lb);
      check($sformatf("v%0d_load_ready", v), {15'd0, rdy_a}, 16'h0000);
      for (int p = 0; p < vecs[v].pairs; p++) begin
        do_launch();
        if (p == 0) begin
          check($sformatf("v%0d_first_a", v), {15'd0, ser_a}, {15'd0, vecs[v].fa});
          check($sformatf("v%0d_first_b", v), {15'd0, ser_b}, {15'd0, vecs[v].fb});
        end
        do_capture();
        if (p == vecs[v].pairs - 2) begin
          check($sformatf("v%0d_ready_early", v), {15'd0, rdy_a}, 16'h0000);
        end
      end
      check($sformatf("v%0d_data_a", v), out_a, vecs[v].ea);
      check($sformatf("v%0d_data_b", v), out_b, vecs[v].eb);
      check($sformatf("v%0d_ready_a", v), {15'd0, rdy_a}, 16'h0001);
      check($sformatf("v%0d_ready_b", v), {15'd0, rdy_b}, 16'h0001);
      for (int p = 0; p < vecs[v].pairs; p++) begin
        do_launch();
        do_capture();
      end
      check($sformatf("v%0d_hold_a", v), out_a, vecs[v].ea);
      check($sformatf("v%0d_hold_b", v), out_b, vecs[v].eb);
      check($sformatf("v%0d_hold_ready", v), {15'd0, rdy_a}, 16'h0001);
    end

    // Same-cycle launch and capture: launch sees the pre-shift register
    do_load(16'h8000, 16'h0000, 2'b01);
    launch = 1'b1; capture = 1'b1;
    tick();
    launch = 1'b0; capture = 1'b0;
    check("lc_same_serial", {15'd0, ser_a}, 16'h0001);
    check("lc_same_data_a", out_a, 16'h0000);

    // Load and reset together: reset wins
    load_a = 16'hFFFF; load_b = 16'hFFFF; ltype = 2'b01; load = 1'b1; rst = 1'b1;
    tick();
    load = 1'b0; rst = 1'b0;
    check("rst_load_data", out_a, 16'h0000);
    check("rst_load_serial", {15'd0, ser_a}, 16'h0000);
    check("rst_load_ready", {15'd0, rdy_a}, 16'h0000);

    // Reset in the middle of a word transfer, then a clean transfer
    do_load(16'hF0F0, 16'h8F0F, 2'b01);
    for (int p = 0; p < 5; p++) begin
      do_launch();
      do_capture();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_data", out_a, 16'h0000);
    check("midrst_ready", {15'd0, rdy_a}, 16'h0000);
    check("midrst_serial", {15'd0, ser_b}, 16'h0000);
    do_load(16'hC3A5, 16'h5A3C, 2'b01);
    for (int p = 0; p < 16; p++) begin
      do_launch();
      do_capture();
    end
    check("after_rst_a", out_a, 16'h5A3C);
    check("after_rst_b", out_b, 16'hC3A5);
    check("after_rst_ready", {15'd0, rdy_b}, 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_ip_shift_register.md
Name: spi_ip_shift_register

Overview:
Parameterised parallel-load / serial-shift register forming the data path of the SPI IP (master and slave). It loads a full word or a half word, then launches one bit per launch strobe and captures one bit per capture strobe, MSB- or LSB-first. It presents the received word in parallel and flags completion. The SPI clock-generation/control block drives the strobes. Two instances cross-connected serial-out to serial-in must exchange their loaded data.

Parameters:
PARAM_SR_WIDTH, 16, word length W in bits; even, >= 4. Half-word length H = W/2.

Ports:
sr_clk_i  input  1  system clock; all state updates on rising edge.
sr_rst_i  input  1  synchronous, active-high reset.
sr_data_load_i  input  W  parallel load data.
sr_load_type_i  input  2  bit0: 1 = word, 0 = half word; bit1: 1 = LSB-first, 0 = MSB-first (00 HW-MSB, 10 HW-LSB, 01 W-MSB, 11 W-LSB).
sr_load_i  input  1  load strobe, one clock.
sr_enable_launch_i  input  1  launch next bit onto serial output.
sr_enable_capture_i  input  1  shift sr_data_serial_i into the register.
sr_enable_launch_capture_i  input  1  global enable; when 0, launch and capture are ignored.
sr_data_serial_i  input  1  serial input.
sr_data_out_o  output  W  parallel register contents (received data).
sr_data_serial_o  output  1  registered serial output.
sr_data_ready_o  output  1  transfer complete.

Behaviour:
- Reset (sr_rst_i = 1 at a clock edge): register = 0, sr_data_serial_o = 0, sr_data_ready_o = 0, bit counter = 0, latched type = 01 (word, MSB-first). Reset overrides everything, including mid-transfer.
- Load (sr_load_i = 1): latch sr_load_type_i; clear the counter and ready.
  - Word: register = sr_data_load_i.
  - Half word: register[H-1:0] = sr_data_load_i[H-1:0]; register[W-1:H] = 0.
  - Load has priority over launch/capture in the same cycle.
  - sr_data_serial_o is not changed by load.
- Length L = W (word) or H (half word).
- Launch (launch & global enable & counter < L): sr_data_serial_o <= selected bit of the current register. The bit is register[L-1] for MSB-first and register[0] for LSB-first.
- Capture (capture & global enable & counter < L): counter += 1, and the active L bits shift.
  - MSB-first: active field <= {field[L-2:0], serial_i}.
  - LSB-first: active field <= {serial_i, field[L-1:1]}.
  - In half-word mode, bits [W-1:H] stay 0.
- Launch and capture asserted in the same cycle: launch samples the register value before the shift.
- When the counter reaches L, sr_data_ready_o <= 1 on that same edge. Ready is a level held until the next load or reset.
- After completion (counter == L), further launch/capture strobes are ignored. The register, serial output and counter hold.
- sr_data_out_o = register contents at all times. After a completed transfer it holds the received L bits, right-aligned, in arrival order according to direction.
- Counter width: clog2(W)+1 bits; it never wraps.
- Expected strobe pattern: alternating launch cycle then capture cycle, L pairs per transfer. Latency from final capture to ready = 1 clock edge (registered).

Test Plan:
- Two instances cross-connected, global enable = 1, load 0x1234 / 0x5678 type 01, then 16 launch/capture pairs -> A.data_out = 0x5678, B.data_out = 0x1234, ready = 1. A further 16 pairs leave both values unchanged.
- Same loopback with 0x1E6A / 0xA6E1, type 11 (word LSB-first), 16 pairs -> A = 0xA6E1, B = 0x1E6A; the first bit launched by A is 0 (the LSB of 0x1E6A).
- Loopback with 0xFF12 / 0xBB34, type 00, 8 pairs -> A = 0x0034, B = 0x0012, ready = 1 after the 8th capture. A second 8-pair burst leaves the values unchanged.
- Loopback with 0xFF1E / 0xBB6A, type 10, 8 pairs -> A = 0x006A, B = 0x001E.
- Global enable = 0 with strobes toggling -> register, counter, serial_o and ready are unchanged. Load and sr_rst_i asserted together -> all outputs 0.
- Reset asserted after 5 captures of a word transfer -> data_out = 0, ready = 0, serial_o = 0. A new load then completes a full transfer normally.
